// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_pick.sv
// Combinational grant selection: round-robin from ptr_i, or lowest-index-wins
// when WB_FIXED_PRIO_EN is defined (the pointer input then disappears).
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef WB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
`ifdef WB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        any_o    = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
        any_o    = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port
// through a one-entry output stage. Define WB_FIXED_PRIO_EN for fixed priority.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic                        reg_wr,
  output logic [ADDR_W-1:0]           waddr,
  output logic [DATA_W-1:0]           wdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   idx;
  logic               any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
`ifndef WB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (req_valid),
`ifndef WB_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any)
  );

  // Grants are blanked during reset so no source believes it was consumed.
  assign req_ready = reset ? '0 : gnt;

  always_comb begin
    sel_addr = req_waddr[int'(idx)*ADDR_W +: ADDR_W];
    sel_data = req_wdata[int'(idx)*DATA_W +: DATA_W];
    reg_wr_d = any && (sel_addr != ADDR_W'(ZERO_REG));
    waddr_d  = any ? sel_addr : waddr_q;
    wdata_d  = any ? sel_data : wdata_q;
    gid_d    = any ? idx : gid_q;
`ifndef WB_FIXED_PRIO_EN
    ptr_d = ptr_q;
    if (any) ptr_d = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      gid_q    <= '0;
`ifndef WB_FIXED_PRIO_EN
      ptr_q    <= '0;
`endif
    end else begin
      reg_wr_q <= reg_wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      gid_q    <= gid_d;
`ifndef WB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign reg_wr   = reg_wr_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign grant_id = gid_q;

  a_one_grant: assert property (@(posedge clk) $onehot0(req_valid & req_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_waddr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic            reg_wr;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  int            mptr = 0;
  logic          exp_wr = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic [1:0]    exp_gid = '0;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .reg_wr    (reg_wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(logic [N-1:0] v, int p);
`ifdef WB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant(req_valid, mptr);
    if (!reset && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    int g;
    logic r;
    r = reset;
    g = model_grant(req_valid, mptr);
    @(posedge clk);
    #1;
    if (r) begin
      mptr = 0; exp_wr = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = '0;
    end else if (g >= 0) begin
      exp_addr = req_waddr[g*AW +: AW];
      exp_data = req_wdata[g*DW +: DW];
      exp_gid  = 2'(g);
      exp_wr   = (exp_addr != 0);
      mptr     = (g + 1) % N;
    end else begin
      exp_wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL rst_reg_wr got %b exp 0", reg_wr); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready got %b exp 000", req_ready); end
      checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr got %h exp 0", waddr); end
      checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", wdata); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid got %0d exp 0", grant_id); end
    end
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready_valid got %b exp 000", req_ready); end
    tick();
    reset = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010; #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", req_ready); end
    tick();
    req_valid = '0; #1;
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL single_wr got %b exp 1", reg_wr); end
    checks++; if (waddr !== 5'd7) begin errors++; $display("FAIL single_waddr got %0d exp 7", waddr); end
    checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got %h exp deadbeef", wdata); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_gid got %0d exp 1", grant_id); end
    tick(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL idle_wr got %b exp 0", reg_wr); end
    checks++; if (waddr !== 5'd7) begin errors++; $display("FAIL idle_hold_waddr got %0d exp 7", waddr); end
  endtask

  task automatic test_x0();
    set_req(2, 5'd0, 32'h12345678);
    req_valid = 3'b100; #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL x0_ready got %b exp 100", req_ready); end
    tick();
    req_valid = '0; #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL x0_wr got %b exp 0", reg_wr); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL x0_gid got %0d exp 2", grant_id); end
    checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL x0_waddr got %0d exp 0", waddr); end
    checks++; if (wdata !== 32'h12345678) begin errors++; $display("FAIL x0_wdata got %h exp 12345678", wdata); end
  endtask

  task automatic test_contention();
    int g;
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
`ifdef WB_FIXED_PRIO_EN
      g = 0;
`else
      g = c % N;
`endif
      #1;
      checks++; if (req_ready !== 3'(1 << g)) begin errors++; $display("FAIL cont_ready[%0d] got %b exp %b", c, req_ready, 3'(1 << g)); end
      tick(); #1;
      checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL cont_wr[%0d] got %b exp 1", c, reg_wr); end
      checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL cont_gid[%0d] got %0d exp %0d", c, grant_id, g); end
      checks++; if (waddr !== 5'(g + 1)) begin errors++; $display("FAIL cont_waddr[%0d] got %0d exp %0d", c, waddr, g + 1); end
    end
    req_valid = '0;
    tick(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL cont_drain_wr got %b exp 0", reg_wr); end
    checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL cont_hold_gid got %0d exp %0d", grant_id, g); end
  endtask

  task automatic test_reset_mid();
    set_req(1, 5'd9, 32'h0000_0009);
    req_valid = 3'b010;
    tick();
    set_req(0, 5'd3, 32'h0000_0003);
    req_valid = 3'b001; reset = 1'b1; #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL midrst_ready got %b exp 000", req_ready); end
    tick(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL midrst_wr got %b exp 0", reg_wr); end
    checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL midrst_waddr got %0d exp 0", waddr); end
    reset = 1'b0; req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midrst_ptr0 got %b exp 001", req_ready); end
    tick();
    req_valid = '0; #1;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd3 || grant_id !== 2'd0) begin
      errors++; $display("FAIL midrst_represent got wr=%b addr=%0d gid=%0d exp wr=1 addr=3 gid=0", reg_wr, waddr, grant_id);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] er;
    int g;
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
        end
      end
      req_valid = pend; #1;
      er = model_ready();
      checks++; if (req_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, er); end
      checks++; if (reg_wr !== exp_wr || waddr !== exp_addr || wdata !== exp_data || grant_id !== exp_gid) begin
        errors++;
        $display("FAIL rand_port[%0d] got wr=%b a=%0d d=%h g=%0d exp wr=%b a=%0d d=%h g=%0d",
                 c, reg_wr, waddr, wdata, grant_id, exp_wr, exp_addr, exp_data, exp_gid);
      end
      g = reset ? -1 : model_grant(req_valid, mptr);
      tick();
      if (g >= 0) pend[g] = 1'b0;
    end
    reset = 1'b0; req_valid = '0;
    tick(); #1;
    checks++; if (reg_wr !== exp_wr || waddr !== exp_addr || wdata !== exp_data || grant_id !== exp_gid) begin
      errors++; $display("FAIL rand_final got wr=%b a=%0d g=%0d exp wr=%b a=%0d g=%0d", reg_wr, waddr, grant_id, exp_wr, exp_addr, exp_gid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_contention();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
